// File: rtl/mem_pattern_checker.sv
// mem_pattern_checker: memory self-test initiator.
// Fills every word with a seed/address-derived pattern, reads it back and
// compares, then repeats with the inverted pattern. It reports pass/fail, a
// saturating mismatch count and the first failing address. The memory ports
// connect directly to a synchronous-write, asynchronous-read memory.
module mem_pattern_checker #(
   parameter int WIDTH = 80,
   parameter int DEPTH = 64,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [15:0]      seed,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [AW+1:0]    err_count,
   output logic             first_err_valid,
   output logic [AW-1:0]    first_err_addr,
   output logic [AW-1:0]    raddr,
   input  logic [WIDTH-1:0] rdata,
   output logic             wen,
   output logic [AW-1:0]    waddr,
   output logic [WIDTH-1:0] wdata
);

   localparam int EW   = AW + 2;
   localparam int NREP = (WIDTH + 15) / 16;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_WR0  = 3'd1;
   localparam logic [2:0] S_RD0  = 3'd2;
   localparam logic [2:0] S_WR1  = 3'd3;
   localparam logic [2:0] S_RD1  = 3'd4;
   localparam logic [2:0] S_DONE = 3'd5;

   // Seed xor address, replicated across the word and optionally inverted.
   function automatic logic [WIDTH-1:0] pattern(input logic [15:0]   sd,
                                                input logic [AW-1:0] a,
                                                input logic          inv);
      logic [15:0]        w;
      logic [NREP*16-1:0] r;
      w = sd ^ 16'(a);
      r = {NREP{w}};
      return r[WIDTH-1:0] ^ {WIDTH{inv}};
   endfunction

   logic [2:0]       state;
   logic [AW-1:0]    cnt;
   logic [15:0]      seed_q;

   logic             wr_p0;
   logic             rd_p0;
   logic             inv_p0;
   logic             last_p0;
   logic             mism_p0;
   logic [WIDTH-1:0] pat_p0;
   logic [EW-1:0]    err_nxt;

   // Decode the current phase and compare the read word against its pattern.
   always_comb begin
      wr_p0   = (state == S_WR0) || (state == S_WR1);
      rd_p0   = (state == S_RD0) || (state == S_RD1);
      inv_p0  = (state == S_WR1) || (state == S_RD1);
      last_p0 = (cnt == AW'(DEPTH - 1));
      pat_p0  = pattern(seed_q, cnt, inv_p0);
      mism_p0 = rd_p0 && (rdata != pat_p0);
      err_nxt = err_count;
      if (mism_p0 && (err_count != {EW{1'b1}}))
         err_nxt = err_count + EW'(1);
   end

   // Memory-side outputs come straight from the state and counter registers,
   // so an asynchronous reset drops wen without waiting for a clock edge.
   assign wen   = wr_p0;
   assign waddr = cnt;
   assign wdata = pat_p0;
   assign raddr = rd_p0 ? cnt : '0;
   assign busy  = wr_p0 || rd_p0;
   assign done  = (state == S_DONE);

   // Sequencer: walks all four sweeps back-to-back, one word per cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         cnt    <= '0;
         seed_q <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  seed_q <= seed;
                  cnt    <= '0;
                  state  <= S_WR0;
               end
            end
            S_WR0: begin
               cnt <= cnt + AW'(1);
               if (last_p0) state <= S_RD0;
            end
            S_RD0: begin
               cnt <= cnt + AW'(1);
               if (last_p0) state <= S_WR1;
            end
            S_WR1: begin
               cnt <= cnt + AW'(1);
               if (last_p0) state <= S_RD1;
            end
            S_RD1: begin
               cnt <= cnt + AW'(1);
               if (last_p0) state <= S_DONE;
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   // Result registers: mismatch count, first failing address, final verdict.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_count       <= '0;
         first_err_valid <= 1'b0;
         first_err_addr  <= '0;
         pass            <= 1'b0;
      end else if ((state == S_IDLE) && start) begin
         err_count       <= '0;
         first_err_valid <= 1'b0;
         first_err_addr  <= '0;
         pass            <= 1'b0;
      end else if (rd_p0) begin
         err_count <= err_nxt;
         if (mism_p0 && !first_err_valid) begin
            first_err_valid <= 1'b1;
            first_err_addr  <= cnt;
         end
         // The last compare lands on the same edge that enters DONE, so the
         // verdict uses the updated count.
         if ((state == S_RD1) && last_p0)
            pass <= (err_nxt == '0);
      end
   end

endmodule

// File: tb/tb_mem_pattern_checker.sv
// tb_mem_pattern_checker: self-checking bench for mem_pattern_checker.
// Hosts a behavioural 80x64 memory with per-bit stuck-at fault masks and
// predicts results from the pattern rule applied word by word.
module tb_mem_pattern_checker;

   localparam int W  = 80;
   localparam int D  = 64;
   localparam int AW = 6;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [15:0]   seed;
   logic          busy;
   logic          done;
   logic          pass;
   logic [AW+1:0] err_count;
   logic          first_err_valid;
   logic [AW-1:0] first_err_addr;
   logic [AW-1:0] raddr;
   logic [W-1:0]  rdata;
   logic          wen;
   logic [AW-1:0] waddr;
   logic [W-1:0]  wdata;

   logic [W-1:0]  mem [D];
   logic [W-1:0]  sa0 [D];
   logic [W-1:0]  sa1 [D];

   int ncmp  = 0;
   int nfail = 0;

   mem_pattern_checker #(.WIDTH(W), .DEPTH(D)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .seed(seed),
      .busy(busy), .done(done), .pass(pass), .err_count(err_count),
      .first_err_valid(first_err_valid), .first_err_addr(first_err_addr),
      .raddr(raddr), .rdata(rdata), .wen(wen), .waddr(waddr), .wdata(wdata)
   );

   always #5 clk = ~clk;

   // Memory: write at the clock edge, combinational read with stuck-at faults.
   always @(posedge clk) if (wen) mem[waddr] <= wdata;
   assign rdata = (mem[raddr] & ~sa0[raddr]) | sa1[raddr];

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_faults();
      for (int a = 0; a < D; a++) begin
         sa0[a] = '0;
         sa1[a] = '0;
      end
   endtask

   // Bit i of the pattern is bit (i mod 16) of seed^address, inverted if asked.
   function automatic logic [W-1:0] ref_pat(input logic [15:0] sd, input int a, input bit inv);
      logic [15:0]  w;
      logic [W-1:0] r;
      w = sd ^ 16'(a);
      for (int i = 0; i < W; i++) r[i] = w[i % 16] ^ inv;
      return r;
   endfunction

   // Expected outcome: each word is read back once per sweep through the faults.
   task automatic model(input logic [15:0] sd, output int e, output int e0,
                        output bit fv, output int fa);
      logic [W-1:0] p;
      logic [W-1:0] got;
      e = 0; e0 = 0; fv = 0; fa = 0;
      for (int inv = 0; inv < 2; inv++) begin
         for (int a = 0; a < D; a++) begin
            p   = ref_pat(sd, a, inv[0]);
            got = (p & ~sa0[a]) | sa1[a];
            if (got !== p) begin
               if (e < (1 << (AW + 2)) - 1) e++;
               if (!fv) begin
                  fv = 1;
                  fa = a;
               end
            end
         end
         if (inv == 0) e0 = e;
      end
   endtask

   task automatic run_test(input string tag, input logic [15:0] sd, input bit poke,
                           output logic [W-1:0] w0, output logic [W-1:0] w1);
      int k, wen_n, sched_bad, e, e0, fa, ph, idx;
      bit fv;
      model(sd, e, e0, fv, fa);
      @(negedge clk); start = 1'b1; seed = sd;
      @(negedge clk); start = 1'b0; seed = 16'($urandom);
      k = 1; wen_n = 0; sched_bad = 0; w0 = '0; w1 = '0;
      chk({tag, "_busy_after_start"}, busy, 1'b1);
      while (!done && k < 4 * D + 20) begin
         ph  = (k - 1) / D;
         idx = (k - 1) % D;
         if (wen) wen_n++;
         if (k == 1) w0 = wdata;
         if (k == 2 * D + 1) w1 = wdata;
         if (k == 2 * D + 1) chk({tag, "_err_after_rd0"}, err_count, e0);
         if (busy !== 1'b1) sched_bad++;
         if (ph % 2 == 0) begin
            if (wen !== 1'b1 || waddr !== AW'(idx) || raddr !== '0 ||
                wdata !== ref_pat(sd, idx, ph == 2)) sched_bad++;
         end else begin
            if (wen !== 1'b0 || raddr !== AW'(idx)) sched_bad++;
         end
         start = poke && (k == 10);
         @(negedge clk); k++;
      end
      start = 1'b0;
      chk({tag, "_done_cycle"}, k, 4 * D + 1);
      chk({tag, "_done"}, done, 1'b1);
      chk({tag, "_busy_in_done"}, busy, 1'b0);
      chk({tag, "_wen_cycles"}, wen_n, 2 * D);
      chk({tag, "_schedule"}, sched_bad, 0);
      chk({tag, "_pass"}, pass, e == 0);
      chk({tag, "_err_count"}, err_count, e);
      chk({tag, "_first_valid"}, first_err_valid, fv);
      chk({tag, "_first_addr"}, first_err_addr, fa);
      if (poke) begin
         start = 1'b1;
         @(negedge clk); start = 1'b0;
         chk({tag, "_done_one_cycle"}, done, 1'b0);
         chk({tag, "_start_in_done_ignored"}, busy, 1'b0);
         chk({tag, "_err_held"}, err_count, e);
         chk({tag, "_pass_held"}, pass, e == 0);
         start = 1'b1;
         @(negedge clk); start = 1'b0;
         chk({tag, "_restart_busy"}, busy, 1'b1);
         chk({tag, "_restart_err_clr"}, err_count, 0);
         chk({tag, "_restart_fv_clr"}, first_err_valid, 1'b0);
         chk({tag, "_restart_pass_clr"}, pass, 1'b0);
         k = 1;
         while (!done && k < 4 * D + 20) begin
            @(negedge clk); k++;
         end
         chk({tag, "_restart_done_cycle"}, k, 4 * D + 1);
         chk({tag, "_restart_err"}, err_count, e);
         @(negedge clk);
      end
   endtask

   task automatic reset_mid(input string tag, input int at_k, input bit exp_wen);
      int k;
      @(negedge clk); start = 1'b1; seed = 16'h0000;
      @(negedge clk); start = 1'b0;
      k = 1;
      while (k < at_k) begin
         @(negedge clk); k++;
      end
      chk({tag, "_err_before_reset"}, err_count, 1);
      chk({tag, "_wen_before_reset"}, wen, exp_wen);
      rst_n = 1'b0;
      #1;
      chk({tag, "_wen_async"}, wen, 1'b0);
      chk({tag, "_busy_async"}, busy, 1'b0);
      chk({tag, "_err_async"}, err_count, 0);
      chk({tag, "_fv_async"}, first_err_valid, 1'b0);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      logic [W-1:0] w0, w1;
      int nf, a, b;
      for (int i = 0; i < D; i++) mem[i] = '0;
      clear_faults();
      rst_n = 1'b0; start = 1'b0; seed = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_pass", pass, 1'b0);
      chk("rst_wen", wen, 1'b0);
      chk("rst_fv", first_err_valid, 1'b0);
      chk("rst_err", err_count, 0);
      chk("rst_faddr", first_err_addr, 0);
      chk("rst_raddr", raddr, 0);
      chk("rst_waddr", waddr, 0);
      chk("rst_wdata", wdata, 0);
      rst_n = 1'b1;
      @(negedge clk);

      run_test("clean", 16'h0000, 1'b0, w0, w1);
      chk("clean_pass_const", pass, 1'b1);

      sa0[5][0] = 1'b1;
      run_test("sa0_a5", 16'h0000, 1'b0, w0, w1);
      chk("sa0_a5_err_const", err_count, 1);
      chk("sa0_a5_addr_const", first_err_addr, 5);

      clear_faults();
      sa1[63][79] = 1'b1;
      sa0[7][0]   = 1'b1;
      run_test("two_faults", 16'h0000, 1'b0, w0, w1);
      chk("two_faults_err_const", err_count, 2);
      chk("two_faults_addr_const", first_err_addr, 7);

      clear_faults();
      run_test("seed_ffff", 16'hFFFF, 1'b0, w0, w1);
      chk("seed_ffff_wr0_word0", w0, {W{1'b1}});
      chk("seed_ffff_wr1_word0", w1, {W{1'b0}});

      sa0[20][3] = 1'b1;
      sa1[41][60] = 1'b1;
      run_test("poke", 16'h1234, 1'b1, w0, w1);

      clear_faults();
      sa0[5][0] = 1'b1;
      reset_mid("rst_rd0", 100, 1'b0);
      reset_mid("rst_wr1", 150, 1'b1);
      clear_faults();
      run_test("after_reset", 16'($urandom), 1'b0, w0, w1);
      chk("after_reset_pass_const", pass, 1'b1);

      for (int r = 0; r < 6; r++) begin
         clear_faults();
         nf = $urandom_range(0, 3);
         for (int f = 0; f < nf; f++) begin
            a = $urandom_range(0, D - 1);
            b = $urandom_range(0, W - 1);
            if ($urandom_range(0, 1) == 1) sa0[a][b] = 1'b1;
            else sa1[a][b] = 1'b1;
         end
         run_test($sformatf("rand%0d", r), 16'($urandom), r[0], w0, w1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
